// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the two requester ports (IF fetch, MEM data) and the memory-side
//   strobe bus of the unified memory arbiter.
//   Parameters: AW address width, DW data width.
//   Modports:
//     slave  - the arbiter: takes requests, returns grants/read data, drives the RAM strobe
//     master - the surrounding pipeline/memory model: the opposite directions
//   Signals:
//     if_req/if_addr -> if_gnt/if_rvalid/if_rdata          IF read port
//     mem_req/mem_we/mem_addr/mem_wdata -> mem_gnt/...      MEM read/write port
//     ram_en/ram_we/ram_addr/ram_wdata, ram_rdata          single-ported memory
interface dmem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the IF fetch port
//   and the MEM data port. At most one access is granted per grantable cycle
//   (IDLE, or WAIT with the latency counter at 0); one read may be outstanding
//   and its data is flagged back to the requester that owns it. Writes finish
//   in their grant cycle. Also counts IF stall cycles (saturating).
//   Build option: define ARB_RR_EN for round-robin between contending
//   requesters; default is fixed MEM-over-IF priority.
//   Ports:
//     clk          clock, all state on the rising edge
//     reset        synchronous active-high reset
//     bus          dmem_port_arbiter_if.slave (requesters + RAM strobe)
//     if_wait_cnt  saturating count of cycles with if_req && !if_gnt
//   Parameters: AW, DW widths; RD_LAT read latency (1..4); CW wait counter width.
module dmem_port_arbiter #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CW     = 16
) (
    input  logic               clk,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus,
    output logic [CW-1:0]      if_wait_cnt
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;
    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_MEM  = 1'b1;
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    logic [0:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] wait_q, wait_d;

    logic          grantable;
    logic          pick_mem;
    logic          if_gnt;
    logic          mem_gnt;
    logic          rd_gnt;
    logic          resp;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    assign grantable = (state_q == ST_IDLE) || (cnt_q == 2'd0);

`ifdef ARB_RR_EN
    // rr_q = 1 means MEM is favoured in the next contested cycle.
    logic rr_q, rr_d;

    assign pick_mem = bus.mem_req && (!bus.if_req || rr_q);
    assign rr_d     = (grantable && bus.if_req && bus.mem_req) ? !pick_mem : rr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign pick_mem = bus.mem_req;
`endif

    assign mem_gnt = grantable && pick_mem;
    assign if_gnt  = grantable && bus.if_req && !pick_mem;
    assign rd_gnt  = if_gnt || (mem_gnt && !bus.mem_we);
    // Read data is due in the last WAIT cycle; a new grant may overlap it.
    assign resp    = (state_q == ST_WAIT) && (cnt_q == 2'd0);

    assign addr_sel  = mem_gnt ? bus.mem_addr : bus.if_addr;
    assign wdata_sel = mem_gnt ? bus.mem_wdata : '0;

    assign bus.if_gnt     = if_gnt;
    assign bus.mem_gnt    = mem_gnt;
    assign bus.ram_en     = if_gnt || mem_gnt;
    assign bus.ram_we     = mem_gnt && bus.mem_we;
    assign bus.ram_addr   = addr_sel;
    assign bus.ram_wdata  = wdata_sel;
    assign bus.if_rvalid  = resp && (owner_q == OWN_IF);
    assign bus.mem_rvalid = resp && (owner_q == OWN_MEM);
    assign bus.if_rdata   = bus.ram_rdata;
    assign bus.mem_rdata  = bus.ram_rdata;
    assign if_wait_cnt    = wait_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (rd_gnt) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
            owner_d = mem_gnt ? OWN_MEM : OWN_IF;
        end else if ((state_q == ST_WAIT) && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (bus.if_req && !if_gnt && (wait_q != {CW{1'b1}})) begin
            wait_d = wait_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            owner_q <= OWN_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end
endmodule
